// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a valid/ready handshake.
// Optional DIV_EARLY_OUT_EN: skip the dividend's leading zeros to shorten the iteration count.
module div_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state, state_n;

   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             q_neg_q;
   logic             r_neg_q;

   logic             is_signed;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic             div_zero;
   logic             overflow;
   logic [CNT_W-1:0] iter_n;
   logic [WIDTH-1:0] dividend_init;
   logic [WIDTH+1:0] diff;
   logic             no_borrow;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // Operand conditioning used during PREP
   always_comb begin
      is_signed = ~op_q[0];
      a_abs     = (is_signed && a_q[WIDTH-1]) ? (WIDTH'(0) - a_q) : a_q;
      b_abs     = (is_signed && b_q[WIDTH-1]) ? (WIDTH'(0) - b_q) : b_q;
      div_zero  = (b_q == '0);
      overflow  = is_signed && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
   end

`ifdef DIV_EARLY_OUT_EN
   logic [CNT_W-1:0] lead;

   // Leading-zero count of |dividend|; the highest set bit wins
   always_comb begin
      lead = CNT_W'(WIDTH);
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (a_abs[i]) lead = CNT_W'(int'(WIDTH) - 1 - i);
      end
      iter_n        = CNT_W'(WIDTH) - lead;
      dividend_init = a_abs << lead;
   end
`else
   always_comb begin
      iter_n        = CNT_W'(WIDTH);
      dividend_init = a_abs;
   end
`endif

   // One restoring step: trial-subtract the divisor from the shifted remainder
   always_comb begin
      diff      = {rem_q, quo_q[WIDTH-1]} - {2'b00, b_q};
      no_borrow = ~diff[WIDTH+1];
      quo_fix   = q_neg_q ? (WIDTH'(0) - quo_q) : quo_q;
      rem_fix   = r_neg_q ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (valid_i) state_n = PREP;
         PREP: begin
            if (div_zero || overflow) state_n = DONE;
            else if (iter_n == '0)    state_n = FIX;
            else                      state_n = ITER;
         end
         ITER: if (cnt_q == CNT_W'(1)) state_n = FIX;
         FIX:  state_n = DONE;
         DONE: if (ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (flush_i) state_n = IDLE;
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i && !flush_i) begin
                  op_q <= op_i;
                  a_q  <= operand_a_i;
                  b_q  <= operand_b_i;
               end
            end
            PREP: begin
               q_neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               r_neg_q <= is_signed & a_q[WIDTH-1];
               b_q     <= b_abs;
               quo_q   <= dividend_init;
               rem_q   <= '0;
               cnt_q   <= iter_n;
            end
            ITER: begin
               rem_q <= no_borrow ? diff[WIDTH:0] : {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
               quo_q <= {quo_q[WIDTH-2:0], no_borrow};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Registered handshake/status outputs track the next state; result loads on completion
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_o  <= 1'b1;
         valid_o  <= 1'b0;
         busy_o   <= 1'b0;
         result_o <= '0;
      end else begin
         ready_o <= (state_n == IDLE);
         valid_o <= (state_n == DONE);
         busy_o  <= (state_n != IDLE);
         if (!flush_i) begin
            if (state == PREP && div_zero)
               result_o <= op_q[1] ? a_q : '1;
            else if (state == PREP && overflow)
               result_o <= op_q[1] ? '0 : a_q;
            else if (state == FIX)
               result_o <= op_q[1] ? rem_fix : quo_fix;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_div_ctrl;
   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         valid_i = 1'b0;
   logic         ready_o;
   logic [1:0]   op_i = 2'b00;
   logic [W-1:0] operand_a_i = '0;
   logic [W-1:0] operand_b_i = '0;
   logic         flush_i = 1'b0;
   logic         valid_o;
   logic         ready_i = 1'b0;
   logic [W-1:0] result_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   div_ctrl #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
      .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // RV32M semantics straight from the ISA rules
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   // Cycles from accept to valid_o: special cases 2, else bit-length-based (or full width) plus 3
   function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag;
      int n;
      if (b == 0) return 2;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      mag = (!op[0] && a[31]) ? (32'h0 - a) : a;
      n = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
`ifdef DIV_EARLY_OUT_EN
      return n + 3;
`else
      if (n < 0) return 0;
      return 35;
`endif
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard;
      guard = 0;
      while (!ready_o && guard < 100) begin step(); guard++; end
      if (guard >= 100) chk("issue_ready_timeout", {31'd0, ready_o}, 32'd1);
      op_i = op; operand_a_i = a; operand_b_i = b; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int hold);
      int lat;
      logic [31:0] exp;
      exp = model(op, a, b);
      issue(op, a, b);
      lat = 1;
      while (!valid_o && lat < 100) begin step(); lat++; end
      chk({tag, "_res"}, result_o, exp);
      chk({tag, "_lat"}, 32'(lat), 32'(model_lat(op, a, b)));
      chk({tag, "_rdy_low"}, {31'd0, ready_o}, 32'd0);
      for (int k = 0; k < hold; k++) begin
         step();
         chk({tag, "_hold_res"}, result_o, exp);
         chk({tag, "_hold_vld"}, {31'd0, valid_o}, 32'd1);
      end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      chk({tag, "_rdy_after"}, {31'd0, ready_o}, 32'd1);
      chk({tag, "_vld_after"}, {31'd0, valid_o}, 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic saw_valid;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_busy",  {31'd0, busy_o},  32'd0);
      chk("rst_result", result_o, 32'd0);
      rst_i = 1'b0;
      step();

      run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 0);
      run_op(OP_REMU, 32'd100, 32'd7, "remu_100_7", 0);
      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2", 0);
      run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2", 0);
      run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, "rem_7_m2", 0);
      run_op(OP_DIV,  32'd5, 32'd0, "div_5_0", 0);
      run_op(OP_REMU, 32'd5, 32'd0, "remu_5_0", 0);
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
      run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
      run_op(OP_DIVU, 32'd3, 32'd1, "divu_3_1", 0);
      run_op(OP_DIVU, 32'd0, 32'd9, "divu_0_9", 0);
      run_op(OP_DIVU, 32'd1000, 32'd33, "backpressure", 5);

      // Flush together with a request in IDLE: not accepted
      op_i = OP_DIVU; operand_a_i = 32'd10; operand_b_i = 32'd2;
      valid_i = 1'b1; flush_i = 1'b1;
      step();
      valid_i = 1'b0; flush_i = 1'b0;
      chk("flush_idle_busy", {31'd0, busy_o}, 32'd0);

      // Flush during the 10th ITER cycle
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd7);
      repeat (10) step();
      chk("pre_flush_busy", {31'd0, busy_o}, 32'd1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush_busy",  {31'd0, busy_o},  32'd0);
      chk("flush_ready", {31'd0, ready_o}, 32'd1);
      saw_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (valid_o) saw_valid = 1'b1;
         step();
      end
      chk("flush_no_valid", {31'd0, saw_valid}, 32'd0);
      run_op(OP_DIVU, 32'd9, 32'd3, "divu_9_3", 0);

      // Asynchronous reset mid-ITER
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
      repeat (5) step();
      rst_i = 1'b1;
      #1;
      chk("arst_ready", {31'd0, ready_o}, 32'd1);
      chk("arst_valid", {31'd0, valid_o}, 32'd0);
      chk("arst_busy",  {31'd0, busy_o},  32'd0);
      chk("arst_result", result_o, 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      step();

      for (int n = 0; n < 60; n++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = pick();
         run_op(rop, ra, rb, "rand", int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
